// File: rtl/rsc_net_if.sv
// Resource network interface: host valid/ready TX/RX FIFOs bridged to a mesh router local port.
// Optional destination filtering on receive is enabled by defining RX_ADDR_CHECK_EN.
module rsc_net_if #(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int FIFO_DEPTH_W = 3,
  parameter int PCKT_DATA_W  = 8,
  parameter int ROW_IDX      = 0,
  parameter int COL_IDX      = 0,
  localparam int RW = (ROW_N > 1) ? $clog2(ROW_N) : 1,
  localparam int CW = (COL_M > 1) ? $clog2(COL_M) : 1,
  localparam int PW = PCKT_DATA_W + RW + CW
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  input  logic [RW-1:0]          tx_row_i,
  input  logic [CW-1:0]          tx_col_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  output logic [PW-1:0]          noc_pckt_o,
  output logic                   noc_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  input  logic [PW-1:0]          noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   noc_full_o,
  output logic                   noc_ovrflw_o,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic [RW-1:0]          rx_row_o,
  output logic [CW-1:0]          rx_col_o,
  output logic                   rx_valid_o,
`ifdef RX_ADDR_CHECK_EN
  output logic                   rx_misroute_o,
`endif
  input  logic                   rx_ready_i
);

  localparam int AW = FIFO_DEPTH_W;
  localparam int D  = 1 << FIFO_DEPTH_W;
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(D);
  localparam logic [AW:0] FULL_THR = (AW+1)'(D - 1);

  typedef enum logic [1:0] {IDLE, SEND, CHECK} tx_state_t;

  // ---------------- TX path ----------------
  logic [PW-1:0] tx_mem [D];
  logic [AW:0]   tx_wr_ptr_reg;
  logic [AW:0]   tx_rd_ptr_reg;
  logic          tx_ready_en_reg;
  tx_state_t     tx_state_reg;
  logic [PW-1:0] noc_pckt_reg;
  logic          noc_wren_reg;
  logic          tx_empty;
  logic          tx_full;
  logic          tx_push;

  assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
  assign tx_full  = (tx_wr_ptr_reg[AW] != tx_rd_ptr_reg[AW]) &&
                    (tx_wr_ptr_reg[AW-1:0] == tx_rd_ptr_reg[AW-1:0]);
  // Ready is held low during reset and comes up on the first edge after release.
  assign tx_ready_o = tx_ready_en_reg && !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign noc_pckt_o = noc_pckt_reg;
  assign noc_wren_o = noc_wren_reg;

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= {tx_row_i, tx_col_i, tx_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_ptr_reg   <= '0;
      tx_ready_en_reg <= 1'b0;
    end else begin
      tx_ready_en_reg <= 1'b1;
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PTR_ONE;
    end
  end

  // The head stays in the FIFO until the router confirms it was not dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_reg  <= IDLE;
      tx_rd_ptr_reg <= '0;
      noc_pckt_reg  <= '0;
      noc_wren_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        IDLE: begin
          noc_wren_reg <= 1'b0;
          if (!tx_empty && !noc_full_i) begin
            noc_pckt_reg <= tx_mem[tx_rd_ptr_reg[AW-1:0]];
            noc_wren_reg <= 1'b1;
            tx_state_reg <= SEND;
          end
        end
        SEND: begin
          noc_wren_reg <= 1'b0;
          tx_state_reg <= CHECK;
        end
        CHECK: begin
          noc_wren_reg <= 1'b0;
          if (!noc_ovrflw_i) tx_rd_ptr_reg <= tx_rd_ptr_reg + PTR_ONE;
          tx_state_reg <= IDLE;
        end
        default: begin
          noc_wren_reg <= 1'b0;
          tx_state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic [PW-1:0] rx_mem [D];
  logic [AW:0]   rx_wr_ptr_reg;
  logic [AW:0]   rx_rd_ptr_reg;
  logic [AW:0]   rx_count_reg;
  logic [AW:0]   rx_count_next;
  logic          noc_full_reg;
  logic          noc_ovrflw_reg;
  logic          rx_full;
  logic          rx_pop;
  logic          rx_push;
  logic          rx_drop;
  logic          addr_ok;
  logic [PW-1:0] rx_head;

`ifdef RX_ADDR_CHECK_EN
  localparam logic [RW+CW-1:0] NODE_ADDR = {RW'(ROW_IDX), CW'(COL_IDX)};
  logic rx_misroute_reg;
  assign addr_ok       = (noc_pckt_i[PW-1:PCKT_DATA_W] == NODE_ADDR);
  assign rx_misroute_o = rx_misroute_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rx_misroute_reg <= 1'b0;
    else         rx_misroute_reg <= noc_wren_i && !addr_ok;
  end
`else
  assign addr_ok = 1'b1;
`endif

  assign rx_full    = (rx_count_reg == CNT_FULL);
  assign rx_valid_o = (rx_count_reg != '0);
  assign rx_pop     = rx_valid_o && rx_ready_i;
  // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
  assign rx_push    = noc_wren_i && addr_ok && (!rx_full || rx_pop);
  assign rx_drop    = noc_wren_i && addr_ok && rx_full && !rx_pop;

  assign rx_head    = rx_mem[rx_rd_ptr_reg[AW-1:0]];
  assign rx_data_o  = rx_head[PCKT_DATA_W-1:0];
  assign rx_col_o   = rx_head[PCKT_DATA_W +: CW];
  assign rx_row_o   = rx_head[PW-1 -: RW];
  assign noc_full_o   = noc_full_reg;
  assign noc_ovrflw_o = noc_ovrflw_reg;

  always_comb begin
    rx_count_next = rx_count_reg;
    if (rx_push && !rx_pop)      rx_count_next = rx_count_reg + PTR_ONE;
    else if (rx_pop && !rx_push) rx_count_next = rx_count_reg - PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= noc_pckt_i;
  end

  // Full is raised one entry early because the router reacts a cycle late.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_wr_ptr_reg  <= '0;
      rx_rd_ptr_reg  <= '0;
      rx_count_reg   <= '0;
      noc_full_reg   <= 1'b0;
      noc_ovrflw_reg <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PTR_ONE;
      rx_count_reg   <= rx_count_next;
      noc_full_reg   <= (rx_count_next >= FULL_THR);
      noc_ovrflw_reg <= rx_drop;
    end
  end

endmodule

// File: tb/tb_rsc_net_if.sv
// Scoreboard bench for rsc_net_if: stimulus pushes expected packets, monitors pop and compare.
module tb_rsc_net_if;
  localparam int PW = 12;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [7:0]    tx_data_i = '0;
  logic [1:0]    tx_row_i = '0;
  logic [1:0]    tx_col_i = '0;
  logic          tx_valid_i = 1'b0;
  logic          tx_ready_o;
  logic [PW-1:0] noc_pckt_o;
  logic          noc_wren_o;
  logic          noc_full_i = 1'b0;
  logic          noc_ovrflw_i = 1'b0;
  logic [PW-1:0] noc_pckt_i = '0;
  logic          noc_wren_i = 1'b0;
  logic          noc_full_o;
  logic          noc_ovrflw_o;
  logic [7:0]    rx_data_o;
  logic [1:0]    rx_row_o;
  logic [1:0]    rx_col_o;
  logic          rx_valid_o;
  logic          rx_ready_i = 1'b0;
`ifdef RX_ADDR_CHECK_EN
  logic          rx_misroute_o;
`endif

  rsc_net_if dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_data_i(tx_data_i), .tx_row_i(tx_row_i), .tx_col_i(tx_col_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .noc_pckt_o(noc_pckt_o), .noc_wren_o(noc_wren_o),
    .noc_full_i(noc_full_i), .noc_ovrflw_i(noc_ovrflw_i),
    .noc_pckt_i(noc_pckt_i), .noc_wren_i(noc_wren_i),
    .noc_full_o(noc_full_o), .noc_ovrflw_o(noc_ovrflw_o),
    .rx_data_o(rx_data_o), .rx_row_o(rx_row_o), .rx_col_o(rx_col_o),
    .rx_valid_o(rx_valid_o),
`ifdef RX_ADDR_CHECK_EN
    .rx_misroute_o(rx_misroute_o),
`endif
    .rx_ready_i(rx_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] tx_exp[$];
  logic [PW-1:0] rx_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [PW-1:0] pk(input int r, input int c, input int d);
    logic [31:0] rv, cv, dv;
    rv = r; cv = c; dv = d;
    return {rv[1:0], cv[1:0], dv[7:0]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_tx_drain(input int budget);
    for (int i = 0; i < budget && tx_exp.size() != 0; i++) tick();
    if (tx_exp.size() != 0) fail("tx_drain_timeout");
  endtask

  task automatic wait_rx_drain(input int budget);
    for (int i = 0; i < budget && rx_exp.size() != 0; i++) tick();
    if (rx_exp.size() != 0) fail("rx_drain_timeout");
  endtask

  // TX monitor: every write strobe towards the router must match the next expected packet.
  always @(negedge clk_i) begin
    if (rst_ni && noc_wren_o) begin
      if (tx_exp.size() == 0) fail("tx_unexpected_wren");
      else check("tx_pckt", 32'(noc_pckt_o), 32'(tx_exp.pop_front()));
    end
  end

  // RX monitor: every host pop must present the next expected packet.
  always @(negedge clk_i) begin
    if (rst_ni && rx_valid_o && rx_ready_i) begin
      if (rx_exp.size() == 0) fail("rx_unexpected_pop");
      else check("rx_head", 32'({rx_row_o, rx_col_o, rx_data_o}), 32'(rx_exp.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int npop;
    // Reset and idle
    tick(3);
    check("ready_in_reset", 32'(tx_ready_o), 0);
    rst_ni = 1'b1;
    tick();
    check("pckt_after_reset", 32'(noc_pckt_o), 0);
    for (int i = 0; i < 10; i++) begin
      check("idle_state", 32'({tx_ready_o, noc_wren_o, rx_valid_o, noc_full_o, noc_ovrflw_o}), 32'h10);
      tick();
    end

    // Single TX
    tx_data_i = 8'hA5; tx_row_i = 2'd2; tx_col_i = 2'd1; tx_valid_i = 1'b1;
    tx_exp.push_back(pk(2, 1, 'hA5));
    tick();
    tx_valid_i = 1'b0;
    wait_tx_drain(20);
    tick(4);
    check("pckt_hold", 32'(noc_pckt_o), 32'(pk(2, 1, 'hA5)));
    check("wren_low_after_send", 32'(noc_wren_o), 0);

    // Backpressure then one retry after a reported overflow
    noc_full_i = 1'b1;
    tx_data_i = 8'h3C; tx_row_i = 2'd1; tx_col_i = 2'd2; tx_valid_i = 1'b1;
    tx_exp.push_back(pk(1, 2, 'h3C));
    tx_exp.push_back(pk(1, 2, 'h3C));
    tick();
    tx_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_no_wren", 32'(noc_wren_o), 0);
      tick();
    end
    noc_full_i = 1'b0;
    for (int i = 0; i < 10 && !noc_wren_o; i++) tick();
    if (!noc_wren_o) fail("bp_wren_timeout");
    tick();
    noc_ovrflw_i = 1'b1;
    tick();
    noc_ovrflw_i = 1'b0;
    wait_tx_drain(20);
    tick(4);

    // TX FIFO fill: ready drops after the 8th write
    noc_full_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tx_data_i = 8'(16 + i); tx_row_i = 2'(i % 3); tx_col_i = 2'((i + 1) % 3);
      tx_valid_i = 1'b1;
      check("tx_ready_fill", 32'(tx_ready_o), (i < 8) ? 1 : 0);
      if (i < 8) tx_exp.push_back(pk(i % 3, (i + 1) % 3, 16 + i));
      tick();
    end
    tx_valid_i = 1'b0;
    noc_full_i = 1'b0;
    wait_tx_drain(60);
    tick(4);
    check("tx_ready_after_drain", 32'(tx_ready_o), 1);

    // RX fill with overflow on the 9th write
    for (int i = 0; i < 9; i++) begin
      noc_pckt_i = pk(i % 3, 2 - (i % 3), 'h40 + i);
      noc_wren_i = 1'b1;
      if (i < 8) rx_exp.push_back(pk(i % 3, 2 - (i % 3), 'h40 + i));
      tick();
      if (i == 5) check("rx_full_after_6", 32'(noc_full_o), 0);
      if (i == 6) check("rx_full_after_7", 32'(noc_full_o), 1);
      if (i == 7) check("rx_ovrflw_after_8", 32'(noc_ovrflw_o), 0);
      if (i == 8) check("rx_ovrflw_after_9", 32'(noc_ovrflw_o), 1);
    end
    noc_wren_i = 1'b0;
    tick();
    check("rx_ovrflw_one_cycle", 32'(noc_ovrflw_o), 0);
    rx_ready_i = 1'b1;
    wait_rx_drain(30);
    rx_ready_i = 1'b0;
    tick();
    check("rx_empty_after_drain", 32'({rx_valid_o, noc_full_o}), 0);

    // RX full with simultaneous pop and write
    for (int i = 0; i < 8; i++) begin
      noc_pckt_i = pk(i % 3, i % 3, 'h80 + i);
      noc_wren_i = 1'b1;
      rx_exp.push_back(pk(i % 3, i % 3, 'h80 + i));
      tick();
    end
    check("rx_full_at_8", 32'(noc_full_o), 1);
    noc_pckt_i = pk(0, 0, 'hC7);
    rx_exp.push_back(pk(0, 0, 'hC7));
    rx_ready_i = 1'b1;
    tick();
    noc_wren_i = 1'b0;
    rx_ready_i = 1'b0;
    check("rx_simul_no_ovrflw", 32'(noc_ovrflw_o), 0);
    check("rx_simul_still_full", 32'(noc_full_o), 1);
    rx_ready_i = 1'b1;
    npop = 0;
    for (int i = 0; i < 30 && rx_valid_o; i++) begin
      tick();
      npop++;
    end
    rx_ready_i = 1'b0;
    check("rx_simul_count", npop, 8);
    check("rx_simul_queue_empty", rx_exp.size(), 0);

`ifdef RX_ADDR_CHECK_EN
    noc_pckt_i = pk(1, 1, 'h55);
    noc_wren_i = 1'b1;
    tick();
    noc_wren_i = 1'b0;
    check("misroute_pulse", 32'({rx_misroute_o, rx_valid_o}), 32'h2);
    tick();
    check("misroute_clear", 32'({rx_misroute_o, rx_valid_o}), 0);
`endif

    // Reset mid-transfer discards buffered packets on both paths
    noc_full_i = 1'b1;
    tx_data_i = 8'hEE; tx_row_i = 2'd1; tx_col_i = 2'd1; tx_valid_i = 1'b1;
    noc_pckt_i = pk(0, 0, 'h11);
    noc_wren_i = 1'b1;
    tick();
    tx_valid_i = 1'b0;
    noc_wren_i = 1'b0;
    check("rx_valid_before_reset", 32'(rx_valid_o), 1);
    rst_ni = 1'b0;
    tick();
    check("reset_mid_state", 32'({tx_ready_o, rx_valid_o}), 0);
    rst_ni = 1'b1;
    noc_full_i = 1'b0;
    tick(6);
    check("post_reset_state", 32'({tx_ready_o, noc_wren_o, rx_valid_o, noc_full_o}), 32'h8);
    check("tx_queue_empty", tx_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rsc_net_if.md
Name: rsc_net_if

Overview:
- Per-node resource network interface between a local resource (host) and one router's local port in mesh_xy_noc.
- TX path: accepts data plus destination over a valid/ready handshake, buffers it, forms a packet, and injects it via the router's resource input channel (pckt/wren/full/ovrflw).
- RX path: consumes packets from the router's resource output channel, buffers them, and presents them to the host over valid/ready.

Parameters:
- ROW_N, 3, mesh rows.
- COL_M, 3, mesh columns.
- FIFO_DEPTH_W, 3, log2 depth of each of the TX and RX FIFOs (depth D = 2^FIFO_DEPTH_W).
- PCKT_DATA_W, 8, payload width.
- ROW_IDX, 0, this node's row.
- COL_IDX, 0, this node's column.
- Derived: RW = $clog2(ROW_N), CW = $clog2(COL_M), PW = PCKT_DATA_W + RW + CW.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- tx_data_i  in  PCKT_DATA_W  payload
- tx_row_i  in  RW  destination row
- tx_col_i  in  CW  destination column
- tx_valid_i  in  1  host offers a packet
- tx_ready_o  out  1  TX FIFO can accept
- noc_pckt_o  out  PW  packet to router, layout {row, col, data}, data in LSBs
- noc_wren_o  out  1  write strobe to router
- noc_full_i  in  1  router local input full
- noc_ovrflw_i  in  1  router reports dropped write
- noc_pckt_i  in  PW  packet from router
- noc_wren_i  in  1  router write strobe
- noc_full_o  out  1  RX buffer full to router
- noc_ovrflw_o  out  1  RX dropped a packet
- rx_data_o  out  PCKT_DATA_W  head payload
- rx_row_o  out  RW  head destination row
- rx_col_o  out  CW  head destination column
- rx_valid_o  out  1  RX FIFO non-empty
- rx_ready_i  in  1  host pops head

Behaviour:
- Reset (async assert, sync release): both FIFOs empty, FSM in IDLE; noc_wren_o = 0, noc_pckt_o = 0, noc_ovrflw_o = 0, noc_full_o = 0, rx_valid_o = 0, tx_ready_o = 1 on the first clock after release (0 while in reset). Reset mid-transfer discards all buffered packets.
- TX FIFO:
  - Write when tx_valid_i && tx_ready_o; tx_ready_o = !tx_full.
  - Pointers are FIFO_DEPTH_W+1 bits, wrapping; full and empty come from MSB compare.
- TX FSM, states IDLE, SEND, CHECK:
  - IDLE: if TX FIFO non-empty && !noc_full_i, register the head into noc_pckt_o, assert noc_wren_o for exactly one cycle, go to SEND.
  - SEND: noc_wren_o = 0. Go to CHECK.
  - CHECK: sample noc_ovrflw_i. If 1, keep the head (no pop) and return to IDLE for a retry. If 0, pop the head and go to IDLE.
  - Maximum throughput is one packet per 3 cycles.
  - The head is never popped before confirmation, so a simultaneous host write and FSM pop on a full FIFO cannot occur. Push and pop in the same cycle when not full are both honoured.
  - noc_pckt_o holds its value when noc_wren_o = 0.
- RX FIFO:
  - Write on noc_wren_i when not full.
  - If noc_wren_i arrives while full: drop the packet and pulse noc_ovrflw_o high for one cycle, registered in the cycle after the write.
  - noc_full_o is registered and asserts when count >= D-1, covering the router's one-cycle reaction delay.
  - Show-ahead read: rx_* reflect the head when rx_valid_o = 1; pop on rx_valid_o && rx_ready_i.
  - Simultaneous write and pop when full: the pop frees a slot, the write is accepted, and there is no overflow.
- Count arithmetic is FIFO_DEPTH_W+1 bits and never wraps past D.

Optional Feature:
- Macro: RX_ADDR_CHECK_EN.
- Defined: a received packet whose {row, col} differs from {ROW_IDX, COL_IDX} is not written to the RX FIFO. Output rx_misroute_o (1 bit, reset 0) pulses for one cycle, registered.
- Undefined: every received packet is buffered regardless of address, and the rx_misroute_o port does not exist.

Test Plan:
- Reset then idle: after rst_ni rises, tx_ready_o = 1, noc_wren_o = 0, rx_valid_o = 0, noc_full_o = 0 -> all hold for 10 cycles.
- Single TX: send data 0xA5 to row 2, col 1 with noc_full_i = 0 -> noc_pckt_o = {2'd2, 2'd1, 8'hA5} with noc_wren_o high for one cycle; FIFO empty 3 cycles later.
- TX backpressure and retry: hold noc_full_i = 1 for 5 cycles -> no wren. Release, then pulse noc_ovrflw_i in CHECK -> the same packet is resent once; 9 host writes with D = 8 -> tx_ready_o drops after the 8th.
- RX fill: 7 router writes with no pops -> noc_full_o = 1 after the 7th. The 9th write -> noc_ovrflw_o pulses once, and 8 packets are popped in order.
- RX full with simultaneous pop and write -> no overflow, count stays 8.
- RX_ADDR_CHECK_EN: receive a packet addressed to (1,1) at node (0,0) -> rx_misroute_o pulses, rx_valid_o stays 0.
